// File: rtl/counter_step_scheduler.sv
// Round-robin scheduler sharing one up/down counter among NREQ multi-step commands.
// Build option: define COUNTER_SAT_EN to make the counter saturate instead of wrapping.
module counter_step_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int STEPW = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         dir,
  input  logic [NREQ*STEPW-1:0]   steps,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [WIDTH-1:0]        value
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [PTRW-1:0]  PTR_ZERO  = {PTRW{1'b0}};
  localparam logic [PTRW-1:0]  PTR_ONE   = {{(PTRW-1){1'b0}}, 1'b1};
  localparam logic [PTRW-1:0]  PTR_LAST  = PTRW'(NREQ - 1);
  localparam logic [STEPW-1:0] STEP_ZERO = {STEPW{1'b0}};
  localparam logic [STEPW-1:0] STEP_ONE  = {{(STEPW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] VAL_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] VAL_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] VAL_MAX   = {WIDTH{1'b1}};
  localparam logic [NREQ-1:0]  REQ_ZERO  = {NREQ{1'b0}};
  localparam logic [NREQ-1:0]  REQ_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One counter step; the saturating build clamps at both ends.
  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] v, input logic down);
    logic [WIDTH-1:0] r;
`ifdef COUNTER_SAT_EN
    if (down) begin
      r = (v == VAL_ZERO) ? v : v - VAL_ONE;
    end else begin
      r = (v == VAL_MAX) ? v : v + VAL_ONE;
    end
`else
    r = down ? (v - VAL_ONE) : (v + VAL_ONE);
`endif
    return r;
  endfunction

  state_e            state_r, state_s;
  logic [PTRW-1:0]   ptr_r, ptr_s;
  logic [PTRW-1:0]   idx_r, idx_s;
  logic              dir_r, dir_s;
  logic [STEPW-1:0]  remaining_r, remaining_s;
  logic [WIDTH-1:0]  value_r, value_s;
  logic [NREQ-1:0]   gnt_r, gnt_s;
  logic [NREQ-1:0]   done_r, done_s;
  logic              busy_r, busy_s;

  logic              sel_found_s;
  logic [PTRW-1:0]   sel_idx_s;
  logic [PTRW-1:0]   cand_s;
  int                cand_sum_s;
  logic              sel_dir_s;
  logic [STEPW-1:0]  sel_steps_s;
  logic [NREQ-1:0]   sel_onehot_s;

  // Round-robin pick: first asserted request scanning upward from ptr, wrapping at NREQ.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = PTR_ZERO;
    cand_s      = PTR_ZERO;
    cand_sum_s  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum_s = int'(ptr_r) + k;
      if (cand_sum_s >= NREQ) begin
        cand_sum_s = cand_sum_s - NREQ;
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_s = PTRW'(cand_sum_s);
      if (!sel_found_s && req[cand_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Fetch the winner's command fields with constant indices.
  always_comb begin
    sel_dir_s   = 1'b0;
    sel_steps_s = STEP_ZERO;
    for (int k = 0; k < NREQ; k++) begin
      if (sel_idx_s == PTRW'(k)) begin
        sel_dir_s   = dir[k];
        sel_steps_s = steps[k*STEPW +: STEPW];
      end else begin
        sel_dir_s   = sel_dir_s;
      end
    end
    sel_onehot_s = REQ_ONE << sel_idx_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    idx_s       = idx_r;
    dir_s       = dir_r;
    remaining_s = remaining_r;
    value_s     = value_r;
    gnt_s       = gnt_r;
    case (state_r)
      IDLE: begin
        if (sel_found_s) begin
          idx_s       = sel_idx_s;
          dir_s       = sel_dir_s;
          remaining_s = sel_steps_s;
          gnt_s       = sel_onehot_s;
          state_s     = (sel_steps_s != STEP_ZERO) ? RUN : DONE;
        end else begin
          state_s     = IDLE;
        end
      end
      RUN: begin
        value_s     = step_value(value_r, dir_r);
        remaining_s = remaining_r - STEP_ONE;
        if (remaining_r == STEP_ONE) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        gnt_s   = REQ_ZERO;
        state_s = IDLE;
        ptr_s   = (idx_r == PTR_LAST) ? PTR_ZERO : (idx_r + PTR_ONE);
      end
      default: begin
        gnt_s   = REQ_ZERO;
        state_s = IDLE;
      end
    endcase
    // done and busy are registered alongside the state they describe.
    done_s = (state_s == DONE) ? gnt_s : REQ_ZERO;
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= PTR_ZERO;
      idx_r       <= PTR_ZERO;
      dir_r       <= 1'b0;
      remaining_r <= STEP_ZERO;
      value_r     <= VAL_ZERO;
      gnt_r       <= REQ_ZERO;
      done_r      <= REQ_ZERO;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      idx_r       <= idx_s;
      dir_r       <= dir_s;
      remaining_r <= remaining_s;
      value_r     <= value_s;
      gnt_r       <= gnt_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
    end
  end

  assign gnt   = gnt_r;
  assign done  = done_r;
  assign busy  = busy_r;
  assign value = value_r;

endmodule

// Protocol checker for counter_step_scheduler outputs.
module counter_step_scheduler_checker #(
  parameter int NREQ = 4
) (
  input logic            clock,
  input logic            reset,
  input logic [NREQ-1:0] gnt,
  input logic [NREQ-1:0] done,
  input logic            busy
);

  localparam logic [NREQ-1:0] REQ_ZERO = {NREQ{1'b0}};

  a_gnt_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(gnt));
  a_done_in_gnt: assert property (@(posedge clock) disable iff (reset) ((done & ~gnt) == REQ_ZERO));
  a_busy_gnt: assert property (@(posedge clock) disable iff (reset) (busy == (gnt != REQ_ZERO)));
  a_done_pulse: assert property (@(posedge clock) disable iff (reset)
                                 (done != REQ_ZERO) |=> (done == REQ_ZERO));

endmodule
